// File: rtl/factor_sequencer.sv
// Sequencer around the factorizer: latches a number, waits for the factor
// vector to settle, then presents each proper divisor in 2..15 for HOLD cycles.
module factor_sequencer #(
    parameter int unsigned SETTLE = 3,
    parameter int unsigned HOLD   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  number_in,
    input  logic [13:0] factors,
    output logic [7:0]  number_out,
    output logic        busy,
    output logic        factor_valid,
    output logic [3:0]  factor_value,
    output logic [3:0]  count,
    output logic        is_prime,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SCAN   = 3'd2,
        S_SHOW   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [13:0] mask;
    logic [13:0] mask_capture;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [7:0]  hold_cnt;

    logic        settle_last;
    logic        hold_last;
    logic        bit_set;
    logic        idx_last;
    logic        enter_done;

    assign settle_last = (settle_cnt == 4'(SETTLE - 1));
    assign hold_last   = (hold_cnt == 8'(HOLD - 1));
    assign bit_set     = mask[idx];
    assign idx_last    = (idx == 4'd13);

    // Keep only divisors strictly below the number; drops n itself and clears 0 and 1.
    always_comb begin
        mask_capture = '0;
        for (int k = 0; k < 14; k++) begin
            mask_capture[k] = factors[k] && ((9'(k) + 9'd2) < {1'b0, number_out});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        enter_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_last) begin
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (bit_set) begin
                    state_next = S_SHOW;
                end else if (idx_last) begin
                    state_next = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_SHOW: begin
                busy = 1'b1;
                if (hold_last) begin
                    if (idx_last) begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            number_out   <= '0;
            count        <= '0;
            is_prime     <= 1'b0;
            factor_valid <= 1'b0;
            factor_value <= '0;
            mask         <= '0;
            idx          <= '0;
            settle_cnt   <= '0;
            hold_cnt     <= '0;
        end else begin
            // is_prime is resolved on the way into DONE so it is already valid while done is high.
            if (enter_done) begin
                is_prime <= (number_out >= 8'd2) && (count == 4'd0);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        number_out <= number_in;
                        count      <= '0;
                        is_prime   <= 1'b0;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_last) begin
                        mask <= mask_capture;
                        idx  <= '0;
                    end
                end
                S_SCAN: begin
                    if (bit_set) begin
                        factor_value <= idx + 4'd2;
                        factor_valid <= 1'b1;
                        count        <= count + 4'd1;
                        hold_cnt     <= '0;
                    end else if (!idx_last) begin
                        idx <= idx + 4'd1;
                    end
                end
                S_SHOW: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_last) begin
                        factor_valid <= 1'b0;
                        factor_value <= '0;
                        if (!idx_last) begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factor_sequencer.sv
// Self-checking bench for factor_sequencer: divisor scoreboard, hold-length
// monitor, done/count/is_prime/latency checks, busy-start and reset-abort cases.
module tb_factor_sequencer;

    localparam int SETTLE = 3;
    localparam int HOLD   = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  number_in;
    logic [13:0] factors;
    logic [7:0]  number_out;
    logic        busy;
    logic        factor_valid;
    logic [3:0]  factor_value;
    logic [3:0]  count;
    logic        is_prime;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];

    factor_sequencer #(.SETTLE(SETTLE), .HOLD(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .number_in    (number_in),
        .factors      (factors),
        .number_out   (number_out),
        .busy         (busy),
        .factor_valid (factor_valid),
        .factor_value (factor_value),
        .count        (count),
        .is_prime     (is_prime),
        .done         (done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-latency factorizer model
    always_comb begin
        factors = '0;
        for (int k = 0; k < 14; k++) begin
            factors[k] = ((number_out % (k + 2)) == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // divisor monitor: value order, stability and hold length
    logic       prev_valid = 1'b0;
    int         run_len    = 0;
    logic [3:0] cur_val    = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            run_len    = 0;
        end else begin
            if (factor_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0) begin
                        check("div_unexpected", factor_value, 4'd0);
                    end else begin
                        check("div_value", factor_value, exp_q.pop_front());
                    end
                    cur_val = factor_value;
                    run_len = 1;
                end else begin
                    check("div_stable", factor_value, cur_val);
                    run_len++;
                end
            end else begin
                if (prev_valid) check("hold_len", run_len, HOLD);
                if (factor_value != 4'd0) check("value_idle", factor_value, 4'd0);
            end
            prev_valid = factor_valid;
        end
    end

    task automatic run_op(input logic [7:0] n, input bit inject);
        int  n_div;
        int  exp_len;
        bit  seen;
        bit  injected;
        n_div = 0;
        for (int d = 2; d <= 15; d++) begin
            if (d < n && (n % d) == 0) begin
                exp_q.push_back(4'(d));
                n_div++;
            end
        end
        exp_len = SETTLE + 14 + n_div * HOLD + 1;
        @(posedge clk); #1;
        start     = 1'b1;
        number_in = n;
        @(posedge clk); #1;
        start     = 1'b0;
        number_in = $urandom_range(0, 255);
        seen      = 1'b0;
        injected  = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (k == 1) check("busy_rise", busy, 1'b1);
            if (inject && !injected && factor_valid) begin
                start     = 1'b1;
                number_in = 8'd7;
                injected  = 1'b1;
            end
            if (done) begin
                seen = 1'b1;
                check("done_len", k, exp_len);
                check("count", count, n_div);
                check("is_prime", is_prime, ref_prime(n));
                check("number_out", number_out, n);
                check("queue_empty", exp_q.size(), 0);
                check("busy_in_done", busy, 1'b1);
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end else begin
            @(negedge clk);
            check("done_pulse", done, 1'b0);
            check("busy_fall", busy, 1'b0);
            check("prime_hold", is_prime, ref_prime(n));
            check("count_hold", count, n_div);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_number_out"}, number_out, 8'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, factor_valid, 1'b0);
        check({tag, "_value"}, factor_value, 4'd0);
        check({tag, "_count"}, count, 4'd0);
        check({tag, "_prime"}, is_prime, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        int  shows;
        int  dones;
        bit  hit;
        reset     = 1'b1;
        start     = 1'b0;
        number_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        run_op(8'd12, 1'b0);
        run_op(8'd13, 1'b0);
        run_op(8'd2, 1'b0);
        run_op(8'd251, 1'b0);
        run_op(8'd0, 1'b0);
        run_op(8'd1, 1'b0);
        run_op(8'd255, 1'b0);
        run_op(8'd169, 1'b0);
        run_op(8'd60, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 1'b0);
        end

        // abort during the second divisor of 12
        @(posedge clk); #1;
        start     = 1'b1;
        number_in = 8'd12;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        shows = 0;
        hit   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (factor_valid && factor_value == 4'd3) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached", hit, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("abort");
        exp_q.delete();
        dones = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (factor_valid) shows++;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_show", shows, 0);
        run_op(8'd12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
